// File: rtl/core_pkg.sv
// Shared core-wide widths and types for the integer datapath.
package core_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: indexed read, x0 forced to zero, and optional
// write-through forwarding when REGFILE_BYPASS_EN is defined.
module regfile_read_port
  import core_pkg::*;
#(
  parameter int unsigned DATA_W = XLEN,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                raddr,
  input  logic [ADDR_W-1:0]                waddr,
  input  logic [DATA_W-1:0]                wdata,
  input  logic                             we,
  output logic [DATA_W-1:0]                rdata
);

`ifndef REGFILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{waddr, wdata, we};
`endif

  always_comb begin
    rdata = regs[raddr];
`ifdef REGFILE_BYPASS_EN
    if (we && (waddr != '0) && (waddr == raddr)) begin
      rdata = wdata;
    end
`endif
    // x0 check last so neither storage nor forwarding can leak a nonzero value.
    if (raddr == '0) begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Integer register file, 2 async read ports and 1 sync write port, x0 hardwired
// to zero. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_2r1w
  import core_pkg::*;
#(
  parameter int unsigned DATA_W = XLEN,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] writedata,
  input  logic              regwrite,
  output logic [DATA_W-1:0] readdata1,
  output logic [DATA_W-1:0] readdata2
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [NumRegs-1:0][DATA_W-1:0] regs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else if (regwrite && (rd != '0)) begin
      regs_q[rd] <= writedata;
    end
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_port1 (
    .regs  (regs_q),
    .raddr (rs1),
    .waddr (rd),
    .wdata (writedata),
    .we    (regwrite),
    .rdata (readdata1)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_port2 (
    .regs  (regs_q),
    .raddr (rs2),
    .waddr (rd),
    .wdata (writedata),
    .we    (regwrite),
    .rdata (readdata2)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w; expectations follow
// REGFILE_BYPASS_EN when it is defined for the build.
module tb_regfile_2r1w;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] writedata;
  logic        regwrite;
  logic [31:0] readdata1, readdata2;

  int unsigned n_total;
  int unsigned n_bad;

  regfile_2r1w dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .writedata (writedata),
    .regwrite  (regwrite),
    .readdata1 (readdata1),
    .readdata2 (readdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    rd        = addr;
    writedata = data;
    regwrite  = 1'b1;
    @(posedge clk);
    #1;
    regwrite  = 1'b0;
  endtask

  initial begin
    logic [31:0] same_cycle_exp;
    n_total   = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    rs1       = 5'd5;
    rs2       = 5'd31;
    rd        = '0;
    writedata = '0;
    regwrite  = 1'b0;

    // Reset state
    #12;
    check_eq("reset_rd1", readdata1, 32'd0);
    check_eq("reset_rd2", readdata2, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_reset_rd1", readdata1, 32'd0);

    // Basic writes x1..x5 = 1..5
    for (int i = 1; i <= 5; i++) write_reg(5'(i), 32'(i));
    rs1 = 5'd1; rs2 = 5'd2; #1;
    check_eq("read_1", readdata1, 32'd1);
    check_eq("read_2", readdata2, 32'd2);
    rs1 = 5'd3; rs2 = 5'd4; #1;
    check_eq("read_3", readdata1, 32'd3);
    check_eq("read_4", readdata2, 32'd4);
    rs1 = 5'd5; rs2 = 5'd2; #1;
    check_eq("read_5", readdata1, 32'd5);
    check_eq("read_2b", readdata2, 32'd2);

    // Same address on both ports
    rs1 = 5'd4; rs2 = 5'd4; #1;
    check_eq("same_addr_rd1", readdata1, 32'd4);
    check_eq("same_addr_rd2", readdata2, 32'd4);

    // x0 protection
    write_reg(5'd0, 32'hDEAD_BEEF);
    rs1 = 5'd0; rs2 = 5'd0; #1;
    check_eq("x0_rd1", readdata1, 32'd0);
    check_eq("x0_rd2", readdata2, 32'd0);

    // Write disable: edges with regwrite low must not modify anything
    @(negedge clk);
    regwrite = 1'b0; rd = 5'd1; writedata = 32'd4;
    @(negedge clk);
    rd = 5'd3; writedata = 32'd6;
    @(negedge clk);
    rs1 = 5'd1; rs2 = 5'd3; #1;
    check_eq("wdis_x1", readdata1, 32'd1);
    check_eq("wdis_x3", readdata2, 32'd3);

    // Same-cycle read/write of x3
`ifdef REGFILE_BYPASS_EN
    same_cycle_exp = 32'd7;
`else
    same_cycle_exp = 32'd3;
`endif
    @(negedge clk);
    regwrite = 1'b1; rd = 5'd3; writedata = 32'd7; rs2 = 5'd3;
    #1;
    check_eq("rw_before_edge", readdata2, same_cycle_exp);
    @(posedge clk);
    #1;
    regwrite = 1'b0;
    #1;
    check_eq("rw_after_edge", readdata2, 32'd7);

    // Forwarding never applies to x0
    @(negedge clk);
    regwrite = 1'b1; rd = 5'd0; writedata = 32'h1234_5678; rs1 = 5'd0;
    #1;
    check_eq("x0_no_forward", readdata1, 32'd0);
    regwrite = 1'b0;

    // Async reset between edges
    rs1 = 5'd2; rs2 = 5'd5; #1;
    check_eq("pre_async_x2", readdata1, 32'd2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_clear_x2", readdata1, 32'd0);
    check_eq("async_clear_x5", readdata2, 32'd0);
    regwrite = 1'b1; rd = 5'd2; writedata = 32'd99;
    @(posedge clk);
    #1;
    regwrite = 1'b0;
`ifdef REGFILE_BYPASS_EN
    #1;
`endif
    check_eq("write_in_reset", readdata1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("after_release_x2", readdata1, 32'd0);

    // Writes resume after reset release
    write_reg(5'd31, 32'hA5A5_0F0F);
    rs2 = 5'd31; #1;
    check_eq("x31_write", readdata2, 32'hA5A5_0F0F);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Integer register file for the pipelined RISC-V-style core: 2 asynchronous read ports, 1 synchronous write port.
- Sits in the decode stage for reads (rs1/rs2) and is written back from the writeback stage (rd).
- Register x0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, address width; register count is 2**ADDR_W (32).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rs1  input  ADDR_W  read address, port 1.
- rs2  input  ADDR_W  read address, port 2.
- rd  input  ADDR_W  write address.
- writedata  input  DATA_W  write data.
- regwrite  input  1  write enable.
- readdata1  output  DATA_W  contents of register rs1.
- readdata2  output  DATA_W  contents of register rs2.

Behaviour:
- Reset: rst_n low clears all registers to 0 immediately, independent of clk.
  - readdata1/readdata2 read 0 during reset and after release until written.
- Write: on posedge clk, with rst_n high, regwrite=1 and rd!=0, reg[rd] <= writedata.
- Write to x0 is silently discarded; reg[0] always reads 0.
- regwrite=0: no register changes, whatever rd/writedata are.
- Read: purely combinational, zero latency.
  - readdata1 = reg[rs1]; readdata2 = reg[rs2].
  - Outputs follow address changes within the same cycle.
- A written value is visible on the read ports immediately after the rising edge that writes it.
- Both read ports are fully independent:
  - rs1==rs2 returns the same value on both.
  - Any combination of rs1, rs2 and rd is legal.
- Same-cycle read/write of one register (feature off): read returns the old value until the edge, then the new value.
- Reset asserted during a write: reset wins; the register ends at 0.
- No X propagation from unwritten registers, since all are reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When regwrite=1, rd!=0 and rd==rs1, readdata1 = writedata combinationally in the same cycle; likewise for rs2/readdata2. Lets writeback and decode share a cycle without a hazard.
- Not defined: no forwarding; same-cycle read returns the pre-write value.
- x0 is never forwarded in either configuration.

Decomposition:
- Shared package core_pkg holds XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and the typedef reg_addr_t/xlen_t.
- One natural sub-module: regfile_read_port. It performs an index read with the x0 zero check and the optional bypass mux, and is instantiated twice.
- Storage array and write logic stay in the top level.

Test Plan:
- Reset then read: pulse rst_n low, rs1=5, rs2=31 -> readdata1=0, readdata2=0.
- Basic writes:
  - stimulus: regwrite=1, write x1..x5 = 1..5 on successive edges; then rs1/rs2 = (1,2), (3,4), (5,2).
  - required: reads 1/2, 3/4, 5/2.
- x0 protection: regwrite=1, rd=0, writedata=0xDEADBEEF, one edge; rs1=0 -> readdata1=0.
- Write disable:
  - stimulus: regwrite=0, rd=1 with writedata=4, then rd=3 with writedata=6, edges applied; rs1=1, rs2=3.
  - required: readdata1=1, readdata2=3 (unchanged).
- Same-cycle read/write:
  - stimulus: regwrite=1, rd=3, writedata=7, rs2=3, sampled before the edge.
  - required without REGFILE_BYPASS_EN: readdata2=3 before the edge, 7 after it.
  - required with REGFILE_BYPASS_EN: readdata2=7 before the edge.
- Async reset mid-operation:
  - stimulus: after x2=2 is written, drop rst_n between clock edges.
  - required: readdata (rs1=2) goes to 0 without a clock edge; a write asserted while rst_n is low has no effect.
